// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the single register-file write port.
// Round-robin or fixed-priority grant, one-cycle registered write stage, saturating contention counter.
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31,
   parameter int FIXED_PRIO = 0,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  rf_write,
   output logic [ADDR_WIDTH-1:0] rf_wrAddr,
   output logic [DATA_WIDTH-1:0] rf_wrData,
   output logic                  last_grant,
   output logic [CNT_WIDTH-1:0]  contention_count
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
   localparam logic                  PRIO_FIX  = (FIXED_PRIO != 0);

   logic                  both_s;
   logic                  open_s;
   logic                  grant_a_s;
   logic                  grant_b_s;
   logic [1:0]            grant_s;

   logic                  rf_write_q,   rf_write_d;
   logic [ADDR_WIDTH-1:0] rf_wr_addr_q, rf_wr_addr_d;
   logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
   logic                  last_grant_q, last_grant_d;
   logic [CNT_WIDTH-1:0]  cnt_q,        cnt_d;

   // Grant decision; on a tie round-robin favours whoever did not win last
   always_comb begin
      both_s    = a_valid & b_valid;
      open_s    = ~reset & ~stall;
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
      if (open_s) begin
         if (both_s) begin
            if (PRIO_FIX || last_grant_q) begin
               grant_a_s = 1'b1;
            end else begin
               grant_b_s = 1'b1;
            end
         end else begin
            grant_a_s = a_valid;
            grant_b_s = b_valid;
         end
      end else begin
         grant_a_s = 1'b0;
         grant_b_s = 1'b0;
      end
      grant_s = {grant_b_s, grant_a_s};
   end

   // Next state of the write stage, grant pointer and contention counter
   always_comb begin
      rf_write_d   = 1'b0;
      rf_wr_addr_d = rf_wr_addr_q;
      rf_wr_data_d = rf_wr_data_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      case (grant_s)
         2'b01: begin
            rf_write_d   = (a_addr != ZERO_ADDR);
            rf_wr_addr_d = a_addr;
            rf_wr_data_d = a_data;
            last_grant_d = 1'b0;
         end
         2'b10: begin
            rf_write_d   = (b_addr != ZERO_ADDR);
            rf_wr_addr_d = b_addr;
            rf_wr_data_d = b_data;
            last_grant_d = 1'b1;
         end
         default: begin
            rf_write_d   = 1'b0;
            last_grant_d = last_grant_q;
         end
      endcase
      // Stalled cycles are not contention: nobody could have been granted
      if (both_s && !stall && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write_q   <= 1'b0;
         rf_wr_addr_q <= {ADDR_WIDTH{1'b0}};
         rf_wr_data_q <= {DATA_WIDTH{1'b0}};
         last_grant_q <= 1'b1;
         cnt_q        <= {CNT_WIDTH{1'b0}};
      end else begin
         rf_write_q   <= rf_write_d;
         rf_wr_addr_q <= rf_wr_addr_d;
         rf_wr_data_q <= rf_wr_data_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   assign a_ready          = grant_a_s;
   assign b_ready          = grant_b_s;
   assign rf_write         = rf_write_q;
   assign rf_wrAddr        = rf_wr_addr_q;
   assign rf_wrData        = rf_wr_data_q;
   assign last_grant       = last_grant_q;
   assign contention_count = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench: two arbiter instances (round-robin and fixed priority), each with its own
// requesters; a reference model predicts readies and the registered write-port state.
module tb_regfile_wb_arbiter;

   localparam int ZR = 31;

   typedef struct {
      logic        wr;
      logic [4:0]  addr;
      logic [63:0] data;
      logic        lg;
      int          cnt;
   } exp_t;

   logic        clk;
   logic        reset, stall;
   logic [1:0]  av, bv, ar, br, rfw, lgo;
   logic [4:0]  aa [2];
   logic [4:0]  ba [2];
   logic [4:0]  rfa [2];
   logic [63:0] ad [2];
   logic [63:0] bd [2];
   logic [63:0] rfd [2];
   logic [15:0] cc [2];

   // requester state [instance][0=A,1=B]
   logic        rq_v [2][2];
   logic [4:0]  rq_a [2][2];
   logic [63:0] rq_d [2][2];

   // reference model state
   logic        m_lg [2];
   int          m_cnt [2];
   logic        m_wr [2];
   logic [4:0]  m_addr [2];
   logic [63:0] m_data [2];

   exp_t q0[$];
   exp_t q1[$];
   int   n_chk = 0;
   int   n_fail = 0;

   regfile_wb_arbiter #(.FIXED_PRIO(0)) u_rr (
      .clk(clk), .reset(reset), .stall(stall),
      .a_valid(av[0]), .a_ready(ar[0]), .a_addr(aa[0]), .a_data(ad[0]),
      .b_valid(bv[0]), .b_ready(br[0]), .b_addr(ba[0]), .b_data(bd[0]),
      .rf_write(rfw[0]), .rf_wrAddr(rfa[0]), .rf_wrData(rfd[0]),
      .last_grant(lgo[0]), .contention_count(cc[0]));

   regfile_wb_arbiter #(.FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset(reset), .stall(stall),
      .a_valid(av[1]), .a_ready(ar[1]), .a_addr(aa[1]), .a_data(ad[1]),
      .b_valid(bv[1]), .b_ready(br[1]), .b_addr(ba[1]), .b_data(bd[1]),
      .rf_write(rfw[1]), .rf_wrAddr(rfa[1]), .rf_wrData(rfd[1]),
      .last_grant(lgo[1]), .contention_count(cc[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // fill: 0 = no new requests, 1 = random new requests, 2 = always re-present (random addr),
   //       3 = always re-present with A->r1, B->r2
   task automatic step(input bit rst, input bit stl, input int fill);
      bit   ga, gb, both;
      exp_t e;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         for (int r = 0; r < 2; r++) begin
            if (!rq_v[i][r] && fill != 0 && (fill >= 2 || $urandom_range(0, 1) == 1)) begin
               rq_v[i][r] = 1'b1;
               rq_a[i][r] = (fill == 3) ? 5'(r + 1) : 5'($urandom_range(0, 31));
               rq_d[i][r] = {$urandom(), $urandom()};
            end
         end
         av[i] = rq_v[i][0]; aa[i] = rq_a[i][0]; ad[i] = rq_d[i][0];
         bv[i] = rq_v[i][1]; ba[i] = rq_a[i][1]; bd[i] = rq_d[i][1];
      end
      reset = rst;
      stall = stl;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         both = rq_v[i][0] && rq_v[i][1];
         ga = 1'b0;
         gb = 1'b0;
         if (!rst && !stl) begin
            if (both) begin
               // instance 1 is fixed priority; round-robin gives A the tie when B won last
               if (i == 1 || m_lg[i] == 1'b1) ga = 1'b1;
               else gb = 1'b1;
            end else begin
               ga = rq_v[i][0];
               gb = rq_v[i][1];
            end
         end
         chk($sformatf("a_ready[%0d]", i), 64'(ar[i]), 64'(ga));
         chk($sformatf("b_ready[%0d]", i), 64'(br[i]), 64'(gb));
         if (rst) begin
            m_lg[i] = 1'b1; m_cnt[i] = 0; m_wr[i] = 1'b0; m_addr[i] = 5'd0; m_data[i] = 64'd0;
         end else begin
            if (both && !stl && m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
            m_wr[i] = 1'b0;
            if (ga || gb) begin
               m_lg[i]   = gb;
               m_addr[i] = rq_a[i][gb ? 1 : 0];
               m_data[i] = rq_d[i][gb ? 1 : 0];
               m_wr[i]   = (m_addr[i] != 5'(ZR));
            end
         end
         e.wr = m_wr[i]; e.addr = m_addr[i]; e.data = m_data[i]; e.lg = m_lg[i]; e.cnt = m_cnt[i];
         if (i == 0) q0.push_back(e);
         else q1.push_back(e);
         if (ga) rq_v[i][0] = 1'b0;
         if (gb) rq_v[i][1] = 1'b0;
      end
   endtask

   task automatic set_req(input int r, input logic [4:0] a, input logic [63:0] d);
      for (int i = 0; i < 2; i++) begin
         rq_v[i][r] = 1'b1;
         rq_a[i][r] = a;
         rq_d[i][r] = d;
      end
   endtask

   // Monitor: compares the registered write port against the expectation queued one cycle earlier
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < 2; i++) begin
            if ((i == 0 && q0.size() > 0) || (i == 1 && q1.size() > 0)) begin
               e = (i == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("rf_write[%0d]", i), 64'(rfw[i]), 64'(e.wr));
               chk($sformatf("rf_wrAddr[%0d]", i), 64'(rfa[i]), 64'(e.addr));
               chk($sformatf("rf_wrData[%0d]", i), rfd[i], e.data);
               chk($sformatf("last_grant[%0d]", i), 64'(lgo[i]), 64'(e.lg));
               chk($sformatf("contention_count[%0d]", i), 64'(cc[i]), 64'(e.cnt));
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      av = 2'b00;
      bv = 2'b00;
      for (int i = 0; i < 2; i++) begin
         aa[i] = 5'd0; ba[i] = 5'd0; ad[i] = 64'd0; bd[i] = 64'd0;
         m_lg[i] = 1'b1; m_cnt[i] = 0; m_wr[i] = 1'b0; m_addr[i] = 5'd0; m_data[i] = 64'd0;
         for (int r = 0; r < 2; r++) begin
            rq_v[i][r] = 1'b0; rq_a[i][r] = 5'd0; rq_d[i][r] = 64'd0;
         end
      end

      // reset with a request pending: must not be accepted
      set_req(0, 5'd7, 64'h1234);
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      for (int i = 0; i < 2; i++) rq_v[i][0] = 1'b0;

      // single A write
      set_req(0, 5'd3, 64'hDEAD_BEEF);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      chk("single_a_addr", 64'(rfa[0]), 64'd3);
      chk("single_a_data", rfd[0], 64'hDEAD_BEEF);

      // tie for 4 cycles, both requesters re-presenting
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 3);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
      chk("tie_count_rr", 64'(cc[0]), 64'd4);
      chk("tie_count_fp", 64'(cc[1]), 64'd4);

      // write to the zero register is accepted but suppressed
      set_req(1, 5'(ZR), 64'd5);
      step(1'b0, 1'b0, 0);
      step(1'b0, 1'b0, 0);
      chk("zero_reg_wr", 64'(rfw[0]), 64'd0);

      // stall with both valid, then release after reset
      step(1'b1, 1'b0, 0);
      set_req(0, 5'd10, 64'hA);
      set_req(1, 5'd11, 64'hB);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);

      // randomized traffic with stalls and occasional resets
      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, 1);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);

      // counter saturation, then reset mid-run
      step(1'b1, 1'b0, 0);
      for (int k = 0; k < 65541; k++) step(1'b0, 1'b0, 2);
      @(posedge clk);
      #1;
      chk("sat_rr", 64'(cc[0]), 64'hFFFF);
      chk("sat_fp", 64'(cc[1]), 64'hFFFF);
      step(1'b1, 1'b0, 2);
      for (int i = 0; i < 2; i++) begin
         rq_v[i][0] = 1'b0;
         rq_v[i][1] = 1'b0;
      end
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 0);
      @(posedge clk);
      #3;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
